// File: rtl/seven_segment_scanner_if.sv
// seven_segment_scanner_if
//   Groups the value/strobe inputs and the display-bus outputs of the
//   seven-segment scanner into one bundle.
//   master : the side that supplies data_in/load/blink_en and watches the bus
//   slave  : the scanner itself
//   Signals:
//     data_in  [DATA_W-1:0] binary value to show (all-ones = blank code)
//     load                  single-cycle conversion strobe
//     blink_en              blinks the whole display when 1
//     seg_n    [6:0]        {a..g}, active-low segments
//     dig_en_n [DIGITS-1:0] one-cold digit enables, bit 0 = units
//     busy                  conversion in progress
//     ovf                   displayed value is out of range
interface seven_segment_scanner_if #(
  parameter int DATA_W = 7,
  parameter int DIGITS = 2
);
  logic [DATA_W-1:0] data_in;
  logic              load;
  logic              blink_en;
  logic [6:0]        seg_n;
  logic [DIGITS-1:0] dig_en_n;
  logic              busy;
  logic              ovf;

  modport master (
    output data_in, load, blink_en,
    input  seg_n, dig_en_n, busy, ovf
  );

  modport slave (
    input  data_in, load, blink_en,
    output seg_n, dig_en_n, busy, ovf
  );
endinterface

// File: rtl/seven_segment_scanner.sv
// seven_segment_scanner
//   Converts a DATA_W-bit binary value into DIGITS BCD digits with a
//   one-bit-per-cycle double-dabble engine, latches the result into a display
//   register, and time-multiplexes that register onto a shared active-low
//   segment bus. Adds leading-zero blanking, overflow dashes, a blank code
//   (all-ones input) and whole-display blinking.
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    seven_segment_scanner_if.slave (data_in, load, blink_en in;
//            seg_n, dig_en_n, busy, ovf out)
module seven_segment_scanner #(
  parameter int DATA_W    = 7,
  parameter int DIGITS    = 2,
  parameter int SCAN_DIV  = 1000,
  parameter int BLINK_DIV = 250,
  parameter int LZ_BLANK  = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  seven_segment_scanner_if.slave  bus
);

  localparam int NIB    = DIGITS + 1;
  localparam int ACC_W  = 4 * NIB;
  localparam int CNT_W  = $clog2(DATA_W + 1);
  localparam int PRE_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int IDX_W  = (DIGITS    > 1) ? $clog2(DIGITS)    : 1;
  localparam int SLOT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b1111110;

  typedef enum logic {IDLE, CONV} state_t;

  function automatic logic [6:0] segCode(input logic [3:0] d);
    case (d)
      4'd0:    segCode = 7'b0000001;
      4'd1:    segCode = 7'b1001111;
      4'd2:    segCode = 7'b0010010;
      4'd3:    segCode = 7'b0000110;
      4'd4:    segCode = 7'b1001100;
      4'd5:    segCode = 7'b0100100;
      4'd6:    segCode = 7'b0100000;
      4'd7:    segCode = 7'b0001111;
      4'd8:    segCode = 7'b0000000;
      4'd9:    segCode = 7'b0000100;
      default: segCode = SEG_BLANK;
    endcase
  endfunction

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               lost_q, lost_d;
  logic               allOnes_q, allOnes_d;
  logic [6:0]         disp_q [DIGITS];
  logic [6:0]         disp_d [DIGITS];
  logic               ovf_q, ovf_d;

  logic [PRE_W-1:0]   presc_q;
  logic [IDX_W-1:0]   idx_q;
  logic [SLOT_W-1:0]  slot_q;
  logic               phase_q;
  logic [6:0]         seg_q;
  logic [DIGITS-1:0]  dig_q;

  logic [ACC_W-1:0]   adj;
  logic [ACC_W-1:0]   accStep;
  logic               lostStep;
  logic               tooBig;
  logic               higherZero;
  logic [3:0]         nib;
  logic [6:0]         commitDisp [DIGITS];
  logic               commitOvf;
  logic               darkOut;

  // One double-dabble step: add-3 correction on every nibble, then shift in
  // the next captured MSB. A 1 pushed out of the top nibble is remembered in
  // lost so values wider than the accumulator still report as overflow.
  always_comb begin
    adj = acc_q;
    for (int n = 0; n < NIB; n++) begin
      if (acc_q[4*n +: 4] >= 4'd5) adj[4*n +: 4] = acc_q[4*n +: 4] + 4'd3;
    end
    accStep  = {adj[ACC_W-2:0], shift_q[DATA_W-1]};
    lostStep = lost_q | adj[ACC_W-1];
  end

  // Display image produced at commit: blank code, overflow dashes, or the BCD
  // digits with zeros above the leading non-zero digit blanked.
  always_comb begin
    tooBig     = lostStep | (accStep[ACC_W-1 -: 4] != 4'd0);
    higherZero = 1'b1;
    nib        = 4'd0;
    commitOvf  = 1'b0;
    for (int i = 0; i < DIGITS; i++) commitDisp[i] = SEG_BLANK;
    if (allOnes_q) begin
      commitOvf = 1'b0;
    end else if (tooBig) begin
      commitOvf = 1'b1;
      for (int i = 0; i < DIGITS; i++) commitDisp[i] = SEG_DASH;
    end else begin
      for (int i = DIGITS - 1; i >= 0; i--) begin
        nib = accStep[4*i +: 4];
        if ((LZ_BLANK != 0) && higherZero && (nib == 4'd0) && (i != 0))
          commitDisp[i] = SEG_BLANK;
        else
          commitDisp[i] = segCode(nib);
        higherZero = higherZero && (nib == 4'd0);
      end
    end
  end

  // Conversion FSM next-state: capture on load in IDLE, one step per cycle in
  // CONV, commit together with the final step.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    lost_d    = lost_q;
    allOnes_d = allOnes_q;
    ovf_d     = ovf_q;
    for (int i = 0; i < DIGITS; i++) disp_d[i] = disp_q[i];
    case (state_q)
      IDLE: begin
        if (bus.load) begin
          shift_d   = bus.data_in;
          acc_d     = '0;
          cnt_d     = CNT_W'(DATA_W);
          lost_d    = 1'b0;
          allOnes_d = &bus.data_in;
          state_d   = CONV;
        end
      end
      CONV: begin
        shift_d = shift_q << 1;
        acc_d   = accStep;
        lost_d  = lostStep;
        cnt_d   = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          for (int i = 0; i < DIGITS; i++) disp_d[i] = commitDisp[i];
          ovf_d   = commitOvf;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Conversion and display registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      lost_q    <= 1'b0;
      allOnes_q <= 1'b0;
      ovf_q     <= 1'b0;
      for (int i = 0; i < DIGITS; i++) disp_q[i] <= SEG_BLANK;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      lost_q    <= lost_d;
      allOnes_q <= allOnes_d;
      ovf_q     <= ovf_d;
      for (int i = 0; i < DIGITS; i++) disp_q[i] <= disp_d[i];
    end
  end

  // Scan timing: prescaler sets the slot length, idx walks the digits, and
  // every digit advance feeds the blink slot counter that flips the phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      idx_q   <= '0;
      slot_q  <= '0;
      phase_q <= 1'b0;
    end else if (presc_q == PRE_W'(SCAN_DIV - 1)) begin
      presc_q <= '0;
      idx_q   <= (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
      if (slot_q == SLOT_W'(BLINK_DIV - 1)) begin
        slot_q  <= '0;
        phase_q <= ~phase_q;
      end else begin
        slot_q  <= slot_q + 1'b1;
      end
    end else begin
      presc_q <= presc_q + 1'b1;
    end
  end

  assign darkOut = bus.blink_en && phase_q;

  // Registered bus drivers; they follow idx and the display one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q <= SEG_BLANK;
      dig_q <= '1;
    end else if (darkOut) begin
      seg_q <= SEG_BLANK;
      dig_q <= '1;
    end else begin
      seg_q <= disp_q[idx_q];
      dig_q <= ~(DIGITS'(1) << idx_q);
    end
  end

  assign bus.seg_n    = seg_q;
  assign bus.dig_en_n = dig_q;
  assign bus.busy     = (state_q == CONV);
  assign bus.ovf      = ovf_q;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// tb_seven_segment_scanner
//   Directed bench for seven_segment_scanner using three instances:
//   u2 (DATA_W=7, DIGITS=2), u8 (DATA_W=8, DIGITS=2), u4 (DATA_W=7, DIGITS=4),
//   all with SCAN_DIV=4, BLINK_DIV=2, LZ_BLANK=1.
module tb_seven_segment_scanner;

  localparam logic [6:0] S0 = 7'b0000001, S1 = 7'b1001111, S2 = 7'b0010010,
                         S3 = 7'b0000110, S4 = 7'b1001100, S5 = 7'b0100100,
                         S7 = 7'b0001111, S9 = 7'b0000100,
                         SB = 7'b1111111, SD = 7'b1111110;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  int   nBusy;

  always #5 clk = ~clk;

  seven_segment_scanner_if #(.DATA_W(7), .DIGITS(2)) if2 ();
  seven_segment_scanner_if #(.DATA_W(8), .DIGITS(2)) if8 ();
  seven_segment_scanner_if #(.DATA_W(7), .DIGITS(4)) if4 ();

  seven_segment_scanner #(.DATA_W(7), .DIGITS(2), .SCAN_DIV(4), .BLINK_DIV(2), .LZ_BLANK(1))
    u2 (.clk(clk), .rst_n(rst_n), .bus(if2));
  seven_segment_scanner #(.DATA_W(8), .DIGITS(2), .SCAN_DIV(4), .BLINK_DIV(2), .LZ_BLANK(1))
    u8 (.clk(clk), .rst_n(rst_n), .bus(if8));
  seven_segment_scanner #(.DATA_W(7), .DIGITS(4), .SCAN_DIV(4), .BLINK_DIV(2), .LZ_BLANK(1))
    u4 (.clk(clk), .rst_n(rst_n), .bus(if4));

  function automatic logic busyOf(input int unit);
    case (unit)
      2:       busyOf = if2.busy;
      8:       busyOf = if8.busy;
      default: busyOf = if4.busy;
    endcase
  endfunction

  task automatic checkVal(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Pulse load for one cycle and count the sampled cycles with busy high.
  task automatic applyStimulus(input int unit, input logic [7:0] value, output int busyCycles);
    @(negedge clk);
    case (unit)
      2:       begin if2.data_in = value[6:0]; if2.load = 1'b1; end
      8:       begin if8.data_in = value;      if8.load = 1'b1; end
      default: begin if4.data_in = value[6:0]; if4.load = 1'b1; end
    endcase
    @(negedge clk);
    if2.load = 1'b0; if8.load = 1'b0; if4.load = 1'b0;
    busyCycles = 0;
    while (busyOf(unit) && busyCycles < 100) begin
      busyCycles++;
      @(negedge clk);
    end
  endtask

  // Wait for digit d to be enabled on the chosen unit, then compare segments.
  task automatic checkOutput(input int unit, input int d, input logic [6:0] expSeg, input string tag);
    logic [3:0] dig, expDig;
    logic [6:0] seg;
    bit         found;
    found  = 1'b0;
    dig    = 4'b1111;
    seg    = 7'b0;
    expDig = 4'b1111 ^ (4'b0001 << d);
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      case (unit)
        2:       begin dig = {2'b11, if2.dig_en_n}; seg = if2.seg_n; end
        8:       begin dig = {2'b11, if8.dig_en_n}; seg = if8.seg_n; end
        default: begin dig = if4.dig_en_n;          seg = if4.seg_n; end
      endcase
      if (dig == expDig) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $error("[TB] FAIL %s: digit %0d enable %b never seen, last %b", tag, d, expDig, dig);
    end else begin
      assert (seg === expSeg) else begin
        errors++;
        $error("[TB] FAIL %s: seg_n observed %b expected %b", tag, seg, expSeg);
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [1:0] exp2;
    logic [3:0] exp4;
    int         idx;
    bit         dark;

    rst_n = 1'b1;
    if2.data_in = '0; if2.load = 1'b0; if2.blink_en = 1'b1;
    if8.data_in = '0; if8.load = 1'b0; if8.blink_en = 1'b0;
    if4.data_in = '0; if4.load = 1'b0; if4.blink_en = 1'b0;

    // Asynchronous reset before any clock edge.
    #1 rst_n = 1'b0;
    #2;
    checkVal("reset_seg",   {1'b0, if2.seg_n},    8'h7f);
    checkVal("reset_dig",   {6'b0, if2.dig_en_n}, 8'h03);
    checkVal("reset_dig4",  {4'b0, if4.dig_en_n}, 8'h0f);
    checkVal("reset_busy",  {7'b0, if2.busy},     8'h00);
    checkVal("reset_ovf",   {7'b0, if2.ovf},      8'h00);

    // Scan order on u4 and blink on u2, counted from reset release.
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      idx  = ((k - 1) / 4) % 2;
      dark = (((k - 1) / 8) % 2) == 1;
      exp2 = dark ? 2'b11 : (2'b11 ^ (2'b01 << idx));
      checkVal($sformatf("blink_dig_k%0d", k), {6'b0, if2.dig_en_n}, {6'b0, exp2});
      if (k <= 20) begin
        idx  = ((k - 1) / 4) % 4;
        exp4 = 4'b1111 ^ (4'b0001 << idx);
        checkVal($sformatf("scan4_dig_k%0d", k), {4'b0, if4.dig_en_n}, {4'b0, exp4});
      end
    end
    if2.blink_en = 1'b0;

    // 42 on two digits.
    applyStimulus(2, 8'd42, nBusy);
    checkVal("busy_len_42", 8'(nBusy), 8'd7);
    checkVal("ovf_42", {7'b0, if2.ovf}, 8'h00);
    checkOutput(2, 0, S2, "d0_42");
    checkOutput(2, 1, S4, "d1_42");

    // Leading-zero blanking.
    applyStimulus(2, 8'd7, nBusy);
    checkOutput(2, 0, S7, "d0_7");
    checkOutput(2, 1, SB, "d1_7");
    applyStimulus(2, 8'd0, nBusy);
    checkOutput(2, 0, S0, "d0_0");
    checkOutput(2, 1, SB, "d1_0");

    // All-ones blank code with DATA_W=7.
    applyStimulus(2, 8'd127, nBusy);
    checkVal("ovf_127_w7", {7'b0, if2.ovf}, 8'h00);
    checkOutput(2, 0, SB, "d0_127_w7");
    checkOutput(2, 1, SB, "d1_127_w7");

    // DATA_W=8: overflow, largest in-range value, blank code.
    applyStimulus(8, 8'd127, nBusy);
    checkVal("busy_len_w8", 8'(nBusy), 8'd8);
    checkVal("ovf_127_w8", {7'b0, if8.ovf}, 8'h01);
    checkOutput(8, 0, SD, "d0_127_w8");
    checkOutput(8, 1, SD, "d1_127_w8");
    applyStimulus(8, 8'd99, nBusy);
    checkVal("ovf_99_w8", {7'b0, if8.ovf}, 8'h00);
    checkOutput(8, 0, S9, "d0_99_w8");
    checkOutput(8, 1, S9, "d1_99_w8");
    applyStimulus(8, 8'd255, nBusy);
    checkVal("ovf_255_w8", {7'b0, if8.ovf}, 8'h00);
    checkOutput(8, 1, SB, "d1_255_w8");

    // Four digits: blanking above the leading digit, inner zero kept.
    applyStimulus(4, 8'd42, nBusy);
    checkOutput(4, 0, S2, "u4_d0_42");
    checkOutput(4, 1, S4, "u4_d1_42");
    checkOutput(4, 2, SB, "u4_d2_42");
    checkOutput(4, 3, SB, "u4_d3_42");
    applyStimulus(4, 8'd105, nBusy);
    checkOutput(4, 0, S5, "u4_d0_105");
    checkOutput(4, 1, S0, "u4_d1_105");
    checkOutput(4, 2, S1, "u4_d2_105");
    checkOutput(4, 3, SB, "u4_d3_105");

    // Load while busy is ignored.
    @(negedge clk);
    if2.data_in = 7'd35; if2.load = 1'b1;
    @(negedge clk);
    if2.load = 1'b0;
    @(negedge clk);
    if2.data_in = 7'd99; if2.load = 1'b1;
    @(negedge clk);
    if2.load = 1'b0;
    nBusy = 2;
    while (if2.busy && nBusy < 100) begin
      nBusy++;
      @(negedge clk);
    end
    checkVal("busy_len_35", 8'(nBusy), 8'd7);
    checkOutput(2, 0, S5, "d0_35");
    checkOutput(2, 1, S3, "d1_35");
    checkVal("busy_after_35", {7'b0, if2.busy}, 8'h00);

    // Reset in the middle of a conversion.
    @(negedge clk);
    if2.data_in = 7'd42; if2.load = 1'b1;
    @(negedge clk);
    if2.load = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkVal("midrst_seg",  {1'b0, if2.seg_n},    8'h7f);
    checkVal("midrst_dig",  {6'b0, if2.dig_en_n}, 8'h03);
    checkVal("midrst_busy", {7'b0, if2.busy},     8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    checkVal("midrst_busy_after", {7'b0, if2.busy}, 8'h00);
    checkVal("midrst_ovf_after",  {7'b0, if2.ovf},  8'h00);
    checkOutput(2, 0, SB, "midrst_d0");
    checkOutput(2, 1, SB, "midrst_d1");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seven_segment_scanner.md
# seven_segment_scanner

Parametrised, clocked successor to the combinational two-digit decoder. It converts a DATA_W-bit binary value to DIGITS BCD digits with an iterative double-dabble engine and holds the result in a display register. It then time-multiplexes the digits onto one shared active-low segment bus with active-low digit enables. It adds leading-zero suppression, overflow indication and a blink mode, and sits between the traffic-light countdown counters and the board's display pins.

## Interface
- DATA_W, 7: width of the binary input value.
- DIGITS, 2: number of multiplexed digits, 1..8.
- SCAN_DIV, 1000: clock cycles per digit slot, >= 2.
- BLINK_DIV, 250: digit slots per blink half-period, >= 1.
- LZ_BLANK, 1: 1 blanks leading zeros; the least-significant digit is never blanked.
- clk  input  1  rising-edge system clock.
- rst_n  input  1  asynchronous, active-low reset.
- data_in  input  DATA_W  binary value. All-ones is the blank code.
- load  input  1  single-cycle strobe; sampled only when busy=0.
- blink_en  input  1  1 enables blinking of the whole display.
- seg_n  output  7  segments {a,b,c,d,e,f,g}, a=MSB, 0=lit. Registered.
- dig_en_n  output  DIGITS  one-cold digit enable; bit 0 is the units digit. Registered.
- busy  output  1  conversion in progress.
- ovf  output  1  displayed value exceeds 10^DIGITS-1.

## Operation
- Segment codes:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
  - blank=1111111, dash=1111110
- Conversion FSM, IDLE -> CONV -> IDLE:
  - In IDLE with load=1, capture data_in, clear the BCD accumulator, set bit counter = DATA_W and go to CONV.
  - CONV does one double-dabble step per cycle: add 3 to every BCD nibble >= 5, then shift left, bringing in the next MSB of the captured value.
  - When the bit counter reaches 0, write the display register and return to IDLE.
- load while busy=1 is ignored; it is neither queued nor allowed to corrupt the conversion.
- Commit rules:
  - Captured value all-ones: every digit is blank, ovf=0.
  - Captured value > 10^DIGITS-1: every digit is dash, ovf=1.
  - Otherwise: show the BCD digits with ovf=0. If LZ_BLANK=1, zero digits above the most-significant non-zero digit are blank, and digit 0 always shows its value.
- The BCD accumulator is DIGITS+1 nibbles wide so that overflow detection is exact. The overflow condition is any non-zero nibble above DIGITS-1.
- Scan:
  - Prescaler counts 0..SCAN_DIV-1. On wrap, the digit index advances 0..DIGITS-1, then back to 0.
  - Each cycle, dig_en_n is registered with bit[idx]=0, and seg_n is registered with the code of digit idx.
- Blink:
  - A slot counter counts digit-index advances, 0..BLINK_DIV-1. On wrap, the blink phase toggles.
  - When blink_en=1 and phase=1, dig_en_n is all ones and seg_n is blank.
  - When blink_en=0, the phase counter keeps running but has no effect.
- The display register is updated only at commit. Scanning never stalls during conversion; it shows the old contents.

## Timing
- Reset, asynchronous: takes effect immediately, with no clock needed.
  - seg_n=1111111, dig_en_n all ones, busy=0, ovf=0, FSM=IDLE.
  - Display register all blank; idx, prescaler, slot counter and phase all 0.
- Reset asserted mid-conversion aborts it. The display returns to blank and no partial result is ever committed.
- load sampled high at edge E:
  - busy=1 after E.
  - Display register and ovf updated at edge E+DATA_W; busy=0 after E+DATA_W.
  - A new load is accepted at edge E+DATA_W+1 at the earliest.
- Output pipeline: seg_n and dig_en_n reflect idx and the display register one cycle after they change.
  - A committed value appears on the bus for the current digit within 1 cycle of commit.
- Digit slot = SCAN_DIV cycles; full frame = DIGITS*SCAN_DIV cycles.
- Blink half-period = BLINK_DIV*SCAN_DIV cycles.
- DIGITS=1: idx stays 0 and dig_en_n[0] is always 0 unless blanked by blink.

## Test plan
- DIGITS=2: load 42 -> busy for exactly 7 cycles. Slot 0 shows seg_n=0010010, dig_en_n=10; slot 1 shows 1001100, dig_en_n=01; ovf=0.
- LZ_BLANK=1: load 7 -> digit0=0001111, digit1=1111111. Then load 0 -> digit0=0000001, digit1 blank.
- Load 127 with DIGITS=2 -> both digits 1111110, ovf=1. Load 127 (all-ones) with DATA_W=7 -> both blank, ovf=0. Run at least one case with DATA_W=8.
- Load 35, then pulse load with 99 two cycles later -> the second load is ignored and the display shows 35. Repeat with rst_n pulsed low mid-conversion -> outputs blank immediately, no commit afterwards.
- SCAN_DIV=4, DIGITS=4 -> dig_en_n cycles 1110, 1101, 1011, 0111, 1110, each held 4 cycles.
- blink_en=1, BLINK_DIV=2, SCAN_DIV=4 -> display on for 8 cycles, then all dark for 8 cycles, repeating.
